sigmoid_arb: RTL and testbench
==============================

SIGMOID_ARB -- requirements
Module: sigmoid_arb

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, meaning the number of requesters sharing one sigmoid LUT (2..8).
REQ-002 The block SHALL have parameter IN_W, default 16, meaning the pre-activation width (Q6.10).
REQ-003 The block SHALL have parameter OUT_W, default 16, meaning the activation width (Q0.16).
REQ-004 The block SHALL have port clk  input  1  meaning the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst  input  1  meaning a synchronous, active-high reset.
REQ-006 The block SHALL have port req_valid  input  N_REQ  meaning request valid per requester.
REQ-007 The block SHALL have port req_x  input  N_REQ*IN_W  meaning the request operand; requester i occupies bits [i*IN_W +: IN_W].
REQ-008 The block SHALL have port req_ready  output  N_REQ  meaning a one-hot-or-zero grant; a request is accepted when req_valid[i] and req_ready[i] are both high.
REQ-009 The block SHALL have port rsp_valid  output  N_REQ  meaning a result is held for requester i.
REQ-010 The block SHALL have port rsp_y  output  N_REQ*OUT_W  meaning the result for requester i at bits [i*OUT_W +: OUT_W].
REQ-011 The block SHALL have port rsp_ready  input  N_REQ  meaning requester i consumes its result.
REQ-012 The block SHALL have port lut_x  output  IN_W  meaning the registered operand driven to the shared LUT.
REQ-013 The block SHALL have port lut_y  input  OUT_W  meaning the LUT output, registered inside the LUT one cycle after lut_x.
REQ-014 The block SHALL have port busy  output  1  meaning any request is in flight or any rsp_valid bit is high.

Function
REQ-015 Eligibility: requester i SHALL be eligible iff req_valid[i]=1, rsp_valid[i]=0, and neither pipeline stage holds tag i.
REQ-016 Arbitration SHALL be round-robin: the search starts at last_grant+1 modulo N_REQ, and the first eligible requester is granted.
REQ-017 req_ready SHALL be combinational from eligibility and last_grant, with at most one bit high per cycle.
REQ-018 last_grant SHALL update to the granted index only on a cycle with an accept; otherwise it SHALL hold.
REQ-019 On an accept edge, lut_x SHALL load the granted req_x slice, stage1 SHALL go valid with tag=index, and a non-accept edge SHALL clear stage1 valid while lut_x holds.
REQ-020 Every edge SHALL move stage1 (valid, tag) into stage2, aligned with lut_y becoming valid.
REQ-021 On an edge with stage2 valid, rsp_y[tag] SHALL load lut_y and rsp_valid[tag] SHALL set.
REQ-022 Latency: accept in cycle 0 SHALL give rsp_valid high from cycle 3, with lut_x stable in cycle 1 and lut_y valid in cycle 2.
REQ-023 Throughput: one accept per cycle SHALL be possible across distinct requesters; the same requester SHALL be re-eligible no earlier than the cycle after its result is consumed.
REQ-024 rsp_valid[i] and rsp_y[i] SHALL hold stable until an edge with rsp_ready[i]=1, which SHALL clear rsp_valid[i]; rsp_ready with rsp_valid=0 SHALL be ignored.
REQ-025 A capture into slot i and a consume of slot i SHALL never coincide, because the eligibility rule excludes it; no priority logic is required.
REQ-026 Requesters SHALL hold req_valid and req_x until accepted; a request withdrawn before accept SHALL have no effect on state.
REQ-027 All N_REQ requesters SHALL be servable with results outstanding simultaneously; no result SHALL ever be dropped or overwritten.

Reset
REQ-028 While rst=1 on an edge: stage1 and stage2 valid SHALL become 0, rsp_valid SHALL become all 0, rsp_y SHALL become 0, lut_x SHALL become 0, and last_grant SHALL become N_REQ-1, giving requester 0 first priority.
REQ-029 Reset mid-operation SHALL discard all in-flight and held results; req_ready SHALL be 0 during any cycle in which rst=1.
REQ-030 busy SHALL be 0 in the cycle after reset.

Verification
REQ-031 Single request, N_REQ=4: req_valid=0001 with x=0x0000 accepted in cycle 0 -> rsp_valid[0]=1 in cycle 3 with rsp_y equal to the LUT model at 0x0000 (0x8000); busy stays 1 until consumed.
REQ-032 All requesters valid continuously with rsp_ready=1 after reset -> grants in the order 0,1,2,3,0,...; each requester gets exactly one grant per window; no cycle has more than one req_ready bit high.
REQ-033 Backpressure: requester 2 with rsp_ready[2]=0 for 20 cycles -> rsp_y[2] stays stable, requester 2 is never re-granted, and requesters 0, 1 and 3 continue to be served.
REQ-034 Back-to-back accepts: requesters 1 and 3 accepted in cycles 0 and 1 with distinct x -> rsp_valid[1] set in cycle 3 and rsp_valid[3] set in cycle 4, with correctly routed values.
REQ-035 rst asserted one cycle after an accept -> no rsp_valid bit ever sets for that request; after release, requester 0 has priority and busy=0.
REQ-036 Random scoreboard: 10k cycles of random req_valid, rsp_ready and x -> every accepted x yields exactly one response, in order per requester, and matches the LUT model.

Source files
------------

// File: rtl/sigmoid_arb.sv
// Round-robin arbiter that shares one registered sigmoid LUT among N_REQ requesters.
// Each requester has one result slot, and that slot holds its result until the requester consumes it.
module sigmoid_arb #(
  parameter int N_REQ = 4,
  parameter int IN_W  = 16,
  parameter int OUT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*IN_W-1:0]  req_x,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [N_REQ*OUT_W-1:0] rsp_y,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [IN_W-1:0]        lut_x,
  input  logic [OUT_W-1:0]       lut_y,
  output logic                   busy
);

  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0]       last_grant_q, last_grant_d;
  logic                   s1_valid_q, s1_valid_d;
  logic [IDX_W-1:0]       s1_tag_q, s1_tag_d;
  logic                   s2_valid_q, s2_valid_d;
  logic [IDX_W-1:0]       s2_tag_q, s2_tag_d;
  logic [IN_W-1:0]        lut_x_q, lut_x_d;
  logic [N_REQ-1:0]       rsp_valid_q, rsp_valid_d;
  logic [N_REQ*OUT_W-1:0] rsp_y_q, rsp_y_d;

  logic [N_REQ-1:0]       elig_s;
  logic [N_REQ-1:0]       grant_oh_s;
  logic [IDX_W-1:0]       grant_idx_s;
  logic                   found_s;
  logic                   hit_s;
  logic                   accept_s;
  logic                   cap_s;
  int                     idx_s;

  // A slot with a request in the pipeline or a held result is ineligible, so capture and consume never collide.
  always_comb begin
    elig_s      = '0;
    grant_oh_s  = '0;
    grant_idx_s = '0;
    found_s     = 1'b0;
    hit_s       = 1'b0;
    idx_s       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      elig_s[i] = req_valid[i] & ~rsp_valid_q[i]
                & ~(s1_valid_q && (s1_tag_q == IDX_W'(i)))
                & ~(s2_valid_q && (s2_tag_q == IDX_W'(i)));
    end
    for (int k = 1; k <= N_REQ; k++) begin
      idx_s             = (int'(last_grant_q) + k) % N_REQ;
      hit_s             = !found_s && elig_s[idx_s];
      grant_oh_s[idx_s] = grant_oh_s[idx_s] | hit_s;
      grant_idx_s       = hit_s ? IDX_W'(idx_s) : grant_idx_s;
      found_s           = found_s | hit_s;
    end
    req_ready = rst ? '0 : grant_oh_s;
    accept_s  = |req_ready;
  end

  always_comb begin
    last_grant_d = accept_s ? grant_idx_s : last_grant_q;
    lut_x_d      = accept_s ? req_x[grant_idx_s*IN_W +: IN_W] : lut_x_q;
    s1_valid_d   = accept_s;
    s1_tag_d     = accept_s ? grant_idx_s : s1_tag_q;
    s2_valid_d   = s1_valid_q;
    s2_tag_d     = s1_tag_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_y_d      = rsp_y_q;
    cap_s        = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cap_s          = s2_valid_q && (s2_tag_q == IDX_W'(i));
      rsp_valid_d[i] = cap_s | (rsp_valid_q[i] & ~rsp_ready[i]);
      rsp_y_d[i*OUT_W +: OUT_W] = cap_s ? lut_y : rsp_y_q[i*OUT_W +: OUT_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= IDX_W'(N_REQ - 1);
      s1_valid_q   <= 1'b0;
      s1_tag_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_tag_q     <= '0;
      lut_x_q      <= '0;
      rsp_valid_q  <= '0;
      rsp_y_q      <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      s1_valid_q   <= s1_valid_d;
      s1_tag_q     <= s1_tag_d;
      s2_valid_q   <= s2_valid_d;
      s2_tag_q     <= s2_tag_d;
      lut_x_q      <= lut_x_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_y_q      <= rsp_y_d;
    end
  end

  assign lut_x     = lut_x_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = rsp_y_q;
  assign busy      = s1_valid_q | s2_valid_q | (|rsp_valid_q);

endmodule

// File: tb/tb_sigmoid_arb.sv
// Bench for sigmoid_arb. A transaction-level model tracks the outstanding result, the accept
// cycle and the expected value for each requester, and an attached LUT model drives lut_y.
module tb_sigmoid_arb;

  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NR*16-1:0] req_x, rsp_y;
  logic [15:0]     lut_x;
  logic [15:0]     lut_y = 16'h0000;
  logic            busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] xs [NR];
  int          last_g;
  bit          outst [NR];
  int          acc_cyc [NR];
  logic [15:0] exp_y [NR];
  int          cyc;
  logic [NR-1:0] exp_ready, exp_rv;
  logic        exp_busy;

  sigmoid_arb #(.N_REQ(NR), .IN_W(16), .OUT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_y(rsp_y), .rsp_ready(rsp_ready),
    .lut_x(lut_x), .lut_y(lut_y), .busy(busy)
  );

  always #5 clk = ~clk;

  // Sigmoid model: a linear region of slope 1/4 around 0.5, clamped to the Q0.16 range.
  function automatic logic [15:0] sig_model(input logic [15:0] x);
    int y;
    y = 32768 + int'($signed(x)) * 16;
    if (y < 0) y = 0;
    if (y > 65535) y = 65535;
    return 16'(y);
  endfunction

  always @(posedge clk) lut_y <= sig_model(lut_x);

  function automatic logic [15:0] rand_x();
    return 16'($urandom_range(0, 4095)) - 16'd2048;
  endfunction

  // Apply inputs for this cycle and derive what the model expects to see in this cycle.
  task automatic drive(input logic r, input logic [NR-1:0] rv, input logic [NR-1:0] rr);
    int idx;
    rst = r; req_valid = rv; rsp_ready = rr;
    for (int i = 0; i < NR; i++) req_x[i*16 +: 16] = xs[i];
    #1;
    exp_ready = '0;
    if (!r) begin
      for (int k = 1; k <= NR; k++) begin
        idx = (last_g + k) % NR;
        if (exp_ready == '0 && rv[idx] && !outst[idx]) exp_ready[idx] = 1'b1;
      end
    end
    exp_busy = 1'b0;
    for (int i = 0; i < NR; i++) begin
      exp_rv[i] = outst[i] && (cyc >= acc_cyc[i] + 3);
      if (outst[i]) exp_busy = 1'b1;
    end
  endtask

  // Advance the model across the clock edge, then move to the next falling edge.
  task automatic tick();
    if (rst) begin
      for (int i = 0; i < NR; i++) outst[i] = 1'b0;
      last_g = NR - 1;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (exp_ready[i]) begin
          outst[i] = 1'b1; acc_cyc[i] = cyc; exp_y[i] = sig_model(xs[i]); last_g = i;
        end
      end
      for (int i = 0; i < NR; i++) if (rsp_ready[i] && exp_rv[i]) outst[i] = 1'b0;
    end
    cyc++;
    @(negedge clk);
    for (int i = 0; i < NR; i++) if (exp_ready[i]) xs[i] = rand_x();
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 4'b1111, 4'b0000);
      n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
      tick();
    end
    drive(1'b0, 4'b0000, 4'b0000);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_tests++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
    n_tests++; if (lut_x !== 16'h0000) begin n_fail++; $display("FAIL reset_lut_x got=%h exp=0000", lut_x); end
    n_tests++; if (rsp_y !== 64'h0) begin n_fail++; $display("FAIL reset_rsp_y got=%h exp=0", rsp_y); end
    tick();
  endtask

  task automatic test_single();
    xs[0] = 16'h0000;
    drive(1'b0, 4'b0001, 4'b0000);
    n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_grant got=%b exp=0001", req_ready); end
    tick();
    for (int c = 1; c < 3; c++) begin
      drive(1'b0, 4'b0000, 4'b0000);
      n_tests++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL single_early c=%0d got=%b exp=0000", c, rsp_valid); end
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy c=%0d got=%b exp=1", c, busy); end
      tick();
    end
    for (int c = 3; c < 7; c++) begin
      drive(1'b0, 4'b0000, (c == 6) ? 4'b0001 : 4'b0000);
      n_tests++; if (rsp_valid !== 4'b0001) begin n_fail++; $display("FAIL single_valid c=%0d got=%b exp=0001", c, rsp_valid); end
      n_tests++; if (rsp_y[15:0] !== 16'h8000) begin n_fail++; $display("FAIL single_y c=%0d got=%h exp=8000", c, rsp_y[15:0]); end
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_hold_busy c=%0d got=%b exp=1", c, busy); end
      tick();
    end
    drive(1'b0, 4'b0000, 4'b0000);
    n_tests++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL single_consume got=%b/%b exp=0000/0", rsp_valid, busy); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] want;
    drive(1'b1, 4'b0000, 4'b0000); tick();
    for (int c = 0; c < 16; c++) begin
      drive(1'b0, 4'b1111, 4'b1111);
      want = 4'b0001 << (c % NR);
      n_tests++; if (req_ready !== want) begin n_fail++; $display("FAIL rr_order c=%0d got=%b exp=%b", c, req_ready, want); end
      n_tests++; if (rsp_valid !== exp_rv) begin n_fail++; $display("FAIL rr_rsp_valid c=%0d got=%b exp=%b", c, rsp_valid, exp_rv); end
      for (int i = 0; i < NR; i++) if (exp_rv[i]) begin
        n_tests++; if (rsp_y[i*16 +: 16] !== exp_y[i]) begin n_fail++; $display("FAIL rr_y c=%0d i=%0d got=%h exp=%h", c, i, rsp_y[i*16 +: 16], exp_y[i]); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int g [NR];
    logic [15:0] held;
    bit have;
    have = 1'b0; held = 16'h0;
    for (int i = 0; i < NR; i++) g[i] = 0;
    for (int c = 0; c < 5; c++) begin drive(1'b0, 4'b0000, 4'b1111); tick(); end
    for (int c = 0; c < 24; c++) begin
      drive(1'b0, 4'b1111, 4'b1011);
      n_tests++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL bp_grant c=%0d got=%b exp=%b", c, req_ready, exp_ready); end
      for (int i = 0; i < NR; i++) if (req_ready[i]) g[i]++;
      if (exp_rv[2]) begin
        n_tests++;
        if (rsp_valid[2] !== 1'b1 || rsp_y[47:32] !== (have ? held : exp_y[2])) begin
          n_fail++; $display("FAIL bp_hold c=%0d got=%b/%h exp=1/%h", c, rsp_valid[2], rsp_y[47:32], have ? held : exp_y[2]);
        end
        if (!have) begin held = exp_y[2]; have = 1'b1; end
      end
      tick();
    end
    n_tests++; if (g[2] != 1) begin n_fail++; $display("FAIL bp_regrant got=%0d exp=1", g[2]); end
    n_tests++; if (g[0] < 3 || g[1] < 3 || g[3] < 3) begin n_fail++; $display("FAIL bp_others got=%0d,%0d,%0d exp>=3 each", g[0], g[1], g[3]); end
    for (int c = 0; c < 5; c++) begin drive(1'b0, 4'b0000, 4'b1111); tick(); end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 5; c++) begin drive(1'b0, 4'b0000, 4'b1111); tick(); end
    xs[1] = 16'h0123;
    drive(1'b0, 4'b0010, 4'b0000);
    n_tests++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL b2b_grant1 got=%b exp=0010", req_ready); end
    tick();
    xs[3] = 16'hFA00;
    drive(1'b0, 4'b1000, 4'b0000);
    n_tests++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL b2b_grant3 got=%b exp=1000", req_ready); end
    n_tests++; if (lut_x !== 16'h0123) begin n_fail++; $display("FAIL b2b_lut_x1 got=%h exp=0123", lut_x); end
    tick();
    drive(1'b0, 4'b0000, 4'b0000);
    n_tests++; if (lut_x !== 16'hFA00 || rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL b2b_cycle2 got=%h/%b exp=fa00/0000", lut_x, rsp_valid); end
    tick();
    drive(1'b0, 4'b0000, 4'b0000);
    n_tests++; if (rsp_valid !== 4'b0010 || rsp_y[31:16] !== 16'h9230) begin n_fail++; $display("FAIL b2b_rsp1 got=%b/%h exp=0010/9230", rsp_valid, rsp_y[31:16]); end
    tick();
    drive(1'b0, 4'b0000, 4'b1010);
    n_tests++; if (rsp_valid !== 4'b1010 || rsp_y[63:48] !== 16'h2000 || rsp_y[31:16] !== 16'h9230) begin
      n_fail++; $display("FAIL b2b_rsp3 got=%b/%h/%h exp=1010/2000/9230", rsp_valid, rsp_y[63:48], rsp_y[31:16]);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 5; c++) begin drive(1'b0, 4'b0000, 4'b1111); tick(); end
    drive(1'b0, 4'b0100, 4'b0000);
    n_tests++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL rmid_grant got=%b exp=0100", req_ready); end
    tick();
    drive(1'b1, 4'b1111, 4'b0000);
    n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rmid_ready_in_rst got=%b exp=0000", req_ready); end
    tick();
    drive(1'b0, 4'b0000, 4'b0000);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    tick();
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 4'b0000, 4'b0000);
      n_tests++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL rmid_dropped c=%0d got=%b exp=0000", c, rsp_valid); end
      tick();
    end
    drive(1'b0, 4'b1111, 4'b0000);
    n_tests++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rmid_priority got=%b exp=0001", req_ready); end
    tick();
  endtask

  task automatic test_random();
    logic r;
    for (int c = 0; c < 10000; c++) begin
      r = ($urandom_range(0, 499) == 0);
      drive(r, 4'($urandom), 4'($urandom));
      n_tests++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_grant c=%0d got=%b exp=%b", c, req_ready, exp_ready); end
      if (!r) begin
        n_tests++; if (rsp_valid !== exp_rv) begin n_fail++; $display("FAIL rnd_rsp_valid c=%0d got=%b exp=%b", c, rsp_valid, exp_rv); end
        n_tests++; if (busy !== exp_busy) begin n_fail++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, busy, exp_busy); end
        for (int i = 0; i < NR; i++) if (exp_rv[i]) begin
          n_tests++; if (rsp_y[i*16 +: 16] !== exp_y[i]) begin n_fail++; $display("FAIL rnd_y c=%0d i=%0d got=%h exp=%h", c, i, rsp_y[i*16 +: 16], exp_y[i]); end
        end
      end
      tick();
    end
    for (int c = 0; c < 6; c++) begin drive(1'b0, 4'b0000, 4'b1111); tick(); end
    drive(1'b0, 4'b0000, 4'b0000);
    n_tests++; if (busy !== 1'b0 || rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL rnd_drain got=%b/%b exp=0/0000", busy, rsp_valid); end
    tick();
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = '0; req_x = '0;
    for (int i = 0; i < NR; i++) begin xs[i] = rand_x(); outst[i] = 1'b0; acc_cyc[i] = 0; exp_y[i] = 16'h0; end
    last_g = NR - 1; cyc = 0;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
